easy_fifo_axis_packer: RTL and testbench
========================================

Name: easy_fifo_axis_packer

Overview:
- AXI-Stream width upsizer placed directly upstream of the synchronous AXIS FIFO, in the write-clock domain.
- Packs RATIO narrow input beats into one wide output beat. Lane 0 holds the first-arrived beat.
- A short packet (tlast) or a flush request closes the word early. tkeep marks the valid lanes.
- The output side connects straight to the FIFO slave port; its width is OUT_DWIDTH.

Parameters:
- IN_DWIDTH, 8: input beat width in bits; must be ≥1.
- RATIO, 4: input beats per output word; must be ≥2.
- OUT_DWIDTH, IN_DWIDTH*RATIO: derived localparam; not overridable.

Ports:
- wr_clk_int  in  1  clock; all logic is posedge.
- rst  in  1  reset: synchronous, active-high.
- s_axis_tdata  in  IN_DWIDTH  narrow input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tready  out  1  input ready.
- flush  in  1  level request to emit a pending partial word.
- m_axis_tdata  out  OUT_DWIDTH  packed data; lane i = bits [i*IN_DWIDTH +: IN_DWIDTH].
- m_axis_tkeep  out  RATIO  per-lane valid mask.
- m_axis_tlast  out  1  word closes a packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready (FIFO not full).
- lane_cnt  out  $clog2(RATIO)  lanes currently held in the accumulator.

Behaviour:
- Reset (synchronous, rst=1 at a wr_clk_int edge) clears everything: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, lane_cnt=0, accumulator=0, accumulator keep=0.
- Reset mid-packet discards the partial word and any unaccepted output word.
- slot_free = ~m_axis_tvalid | m_axis_tready.
- s_axis_tready = slot_free, purely combinational; it never depends on s_axis_tdata, s_axis_tvalid or s_axis_tlast.
- acc_hs = s_axis_tvalid & s_axis_tready.
- On acc_hs with close = (lane_cnt==RATIO-1) | s_axis_tlast:
  - m_axis_tdata <= accumulator with the current beat placed in lane lane_cnt; lanes above lane_cnt are zero.
  - m_axis_tkeep <= (1 << (lane_cnt+1)) - 1.
  - m_axis_tlast <= s_axis_tlast; m_axis_tvalid <= 1.
  - lane_cnt <= 0; accumulator and its keep cleared.
- On acc_hs without close: the beat is written into lane lane_cnt and lane_cnt increments. The output register is untouched, apart from the drain rule below.
- Flush fires only when flush=1, acc_hs=0, lane_cnt>0 and slot_free=1:
  - Emits the accumulator with keep = (1 << lane_cnt) - 1 and m_axis_tlast=0.
  - Clears lane_cnt and the accumulator.
- Flush is ignored in any cycle that has an input handshake; it remains effective in a later cycle if still held.
- Flush with lane_cnt==0 emits nothing.
- Drain: if m_axis_tvalid & m_axis_tready and no new word is loaded that cycle, m_axis_tvalid <= 0.
- Back-to-back operation: a completing beat and an output handshake in the same cycle replace the word with no bubble.
- Latency: an output word is valid the cycle after the closing input handshake, or after the flush cycle.
- Throughput: one input beat per cycle while downstream stays ready.
- Stall: while m_axis_tvalid=1 and m_axis_tready=0, s_axis_tready=0. The output word, tkeep and tlast stay stable, as AXIS requires.
- tlast on the first lane produces keep = 0…01.
- lane_cnt wraps only through close or flush; it never exceeds RATIO-1.
- No backpressure dependence: tvalid never depends on m_axis_tready.

Decomposition:
- Package easy_fifo_axis_pkg holds:
  - function keep_mask(n, RATIO) returning (1<<n)-1;
  - localparam helper LANE_W = (RATIO>1) ? $clog2(RATIO) : 1.
- No sub-module. The lane accumulator and the output register are single always_ff blocks in this module.
- Integrates ahead of easy_fifo_axis_sync with DWIDTH = OUT_DWIDTH + RATIO + 1 ({tlast, tkeep, tdata}).

Test Plan:
- Reset, then 4 beats 0x11, 0x22, 0x33, 0x44 with tlast on the 4th, m_axis_tready=1 → one word 0x44332211, tkeep=4'hF, tlast=1, valid one cycle after the 4th beat.
- Beats 0xA1, 0xA2 with tlast on the 2nd → word 0x0000A2A1, tkeep=4'h3, tlast=1.
- 3 beats 0x01, 0x02, 0x03 with no tlast, then flush=1 with tvalid=0 → word 0x00030201, tkeep=4'h7, tlast=0, and lane_cnt returns to 0.
- Hold m_axis_tready=0 with a word pending, drive 2 more beats → s_axis_tready=0, the word stays stable, no beat is lost. Release ready → the word is accepted and the next beats are packed correctly.
- Continuous 8 beats 0x00..0x07 with ready=1 → words 0x03020100 then 0x07060504, no bubble, tkeep=4'hF on both.
- Assert rst after 2 beats 0xEE, 0xFF → all outputs 0 next cycle; the next 4 beats 0x10..0x13 produce 0x13121110 with no stale lanes.

Source files
------------

// File: rtl/easy_fifo_axis_pkg.sv
// Shared helpers for the AXIS packer: lane keep masks and lane-counter sizing.
package easy_fifo_axis_pkg;

    // Low n bits set, clamped to the lane count so a full word never overflows.
    function automatic int unsigned keep_mask(input int unsigned n, input int unsigned ratio);
        int unsigned m;
        m = (n >= ratio) ? ratio : n;
        if (m >= 32) begin
            return '1;
        end
        return (32'd1 << m) - 32'd1;
    endfunction

    function automatic int lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/easy_fifo_axis_packer.sv
// AXIS upsizer: RATIO narrow beats -> one wide word, closed early by tlast or flush; 1-cycle latency.
// Input ready is the output slot being free, so a stalled output word holds the input off.
module easy_fifo_axis_packer
    import easy_fifo_axis_pkg::*;
#(
    parameter int IN_DWIDTH = 8,
    parameter int RATIO     = 4,
    localparam int OUT_DWIDTH = IN_DWIDTH * RATIO
) (
    input  logic                      wr_clk_int,
    input  logic                      rst,
    input  logic [IN_DWIDTH-1:0]      s_axis_tdata,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,
    input  logic                      flush,
    output logic [OUT_DWIDTH-1:0]     m_axis_tdata,
    output logic [RATIO-1:0]          m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [$clog2(RATIO)-1:0]  lane_cnt
);

    localparam int LANE_W = lane_w(RATIO);

    logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
    logic [OUT_DWIDTH-1:0] acc_q, acc_d;
    logic [RATIO-1:0]      acc_keep_q, acc_keep_d;
    logic [OUT_DWIDTH-1:0] out_dat_q, out_dat_d;
    logic [RATIO-1:0]      out_keep_q, out_keep_d;
    logic                  out_last_q, out_last_d;
    logic                  out_vld_q, out_vld_d;

    logic                  slot_free;
    logic                  acc_hs;
    logic                  close;
    logic                  flush_fire;
    logic [OUT_DWIDTH-1:0] merged;
    logic [RATIO-1:0]      merged_keep;
    logic [31:0]           close_keep;

    assign slot_free  = ~out_vld_q | m_axis_tready;
    assign acc_hs     = s_axis_tvalid & slot_free;
    assign close      = acc_hs & ((lane_cnt_q == LANE_W'(RATIO - 1)) | s_axis_tlast);
    assign flush_fire = flush & ~acc_hs & (lane_cnt_q != '0) & slot_free;
    assign close_keep = keep_mask(32'(lane_cnt_q) + 32'd1, RATIO);

    // Lanes above lane_cnt are always zero in the accumulator, so merging only writes one lane.
    always_comb begin
        merged      = acc_q;
        merged_keep = acc_keep_q;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_cnt_q == LANE_W'(i)) begin
                merged[i*IN_DWIDTH +: IN_DWIDTH] = s_axis_tdata;
                merged_keep[i]                   = 1'b1;
            end
        end
    end

    always_comb begin
        lane_cnt_d = lane_cnt_q;
        acc_d      = acc_q;
        acc_keep_d = acc_keep_q;
        if (close || flush_fire) begin
            lane_cnt_d = '0;
            acc_d      = '0;
            acc_keep_d = '0;
        end else if (acc_hs) begin
            lane_cnt_d = lane_cnt_q + LANE_W'(1);
            acc_d      = merged;
            acc_keep_d = merged_keep;
        end
    end

    always_comb begin
        out_dat_d  = out_dat_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        out_vld_d  = out_vld_q;
        if (out_vld_q && m_axis_tready) begin
            out_vld_d = 1'b0;
        end
        if (close) begin
            out_dat_d  = merged;
            out_keep_d = close_keep[RATIO-1:0];
            out_last_d = s_axis_tlast;
            out_vld_d  = 1'b1;
        end else if (flush_fire) begin
            out_dat_d  = acc_q;
            out_keep_d = acc_keep_q;
            out_last_d = 1'b0;
            out_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge wr_clk_int) begin
        if (rst) begin
            lane_cnt_q <= '0;
            acc_q      <= '0;
            acc_keep_q <= '0;
        end else begin
            lane_cnt_q <= lane_cnt_d;
            acc_q      <= acc_d;
            acc_keep_q <= acc_keep_d;
        end
    end

    always_ff @(posedge wr_clk_int) begin
        if (rst) begin
            out_dat_q  <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
        end else begin
            out_dat_q  <= out_dat_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign s_axis_tready = slot_free;
    assign m_axis_tdata  = out_dat_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tvalid = out_vld_q;
    assign lane_cnt      = lane_cnt_q;

endmodule

// File: tb/tb_easy_fifo_axis_packer.sv
// Scoreboard bench for easy_fifo_axis_packer (IN_DWIDTH=8, RATIO=4).
module tb_easy_fifo_axis_packer;

    logic        wr_clk_int = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic        flush = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [1:0]  lane_cnt;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  keep;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    easy_fifo_axis_packer #(.IN_DWIDTH(8), .RATIO(4)) dut (
        .wr_clk_int    (wr_clk_int),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .flush         (flush),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .lane_cnt      (lane_cnt)
    );

    always #5 wr_clk_int = ~wr_clk_int;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [3:0] k, input logic l);
        exp_t e;
        e.dat  = d;
        e.keep = k;
        e.last = l;
        sb.push_back(e);
    endtask

    // Output monitor: every accepted word is popped from the scoreboard and compared.
    always @(negedge wr_clk_int) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 64'(m_axis_tdata), 64'hDEAD_0000_0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word_data", 64'(m_axis_tdata), 64'(e.dat));
                chk("word_keep", 64'(m_axis_tkeep), 64'(e.keep));
                chk("word_last", 64'(m_axis_tlast), 64'(e.last));
            end
        end
    end

    // Returns at posedge+1 right after the beat was accepted.
    task automatic send(input logic [7:0] d, input logic l);
        int waited;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        waited = 0;
        forever begin
            @(negedge wr_clk_int);
            if (s_axis_tready) begin
                @(posedge wr_clk_int);
                #1;
                break;
            end
            waited++;
            if (waited > 100) begin
                chk("send_timeout", 64'(waited), 64'd0);
                break;
            end
        end
    endtask

    task automatic idle();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic tick();
        @(posedge wr_clk_int);
        #1;
    endtask

    initial begin
        time t0;

        // Reset state
        repeat (2) tick();
        @(negedge wr_clk_int);
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("rst_lane_cnt", 64'(lane_cnt), 64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd1);
        tick();
        rst = 1'b0;

        // Full packet of four beats
        push_exp(32'h44332211, 4'hF, 1'b1);
        send(8'h11, 1'b0);
        chk("lane_after_1", 64'(lane_cnt), 64'd1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        idle();
        @(negedge wr_clk_int);
        chk("latency_full", 64'(m_axis_tvalid), 64'd1);
        tick();

        // Short packet
        push_exp(32'h0000A2A1, 4'h3, 1'b1);
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b1);
        idle();
        tick();

        // Flush of a three-lane partial word
        push_exp(32'h00030201, 4'h7, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        idle();
        chk("lane_before_flush", 64'(lane_cnt), 64'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("lane_after_flush", 64'(lane_cnt), 64'd0);
        chk("flush_latency", 64'(m_axis_tvalid), 64'd1);
        tick();

        // Flush with nothing pending emits nothing
        flush = 1'b1;
        repeat (2) tick();
        flush = 1'b0;
        @(negedge wr_clk_int);
        chk("flush_empty", 64'(m_axis_tvalid), 64'd0);
        tick();

        // Flush is ignored during a handshake and acts once the input goes idle
        push_exp(32'h00006655, 4'h3, 1'b0);
        send(8'h55, 1'b0);
        flush = 1'b1;
        send(8'h66, 1'b0);
        chk("flush_ignored_hs", 64'(lane_cnt), 64'd2);
        idle();
        tick();
        flush = 1'b0;
        chk("flush_held_lane", 64'(lane_cnt), 64'd0);
        tick();

        // Output stall
        m_axis_tready = 1'b0;
        push_exp(32'hD4D3D2D1, 4'hF, 1'b1);
        push_exp(32'h0000E2E1, 4'h3, 1'b1);
        send(8'hD1, 1'b0);
        send(8'hD2, 1'b0);
        send(8'hD3, 1'b0);
        send(8'hD4, 1'b1);
        s_axis_tdata  = 8'hE1;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wr_clk_int);
            chk("stall_tready", 64'(s_axis_tready), 64'd0);
            chk("stall_tdata", 64'(m_axis_tdata), 64'hD4D3D2D1);
            chk("stall_tkeep", 64'(m_axis_tkeep), 64'hF);
            chk("stall_lane", 64'(lane_cnt), 64'd0);
        end
        tick();
        m_axis_tready = 1'b1;
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b1);
        idle();
        tick();

        // Continuous stream, no bubbles
        push_exp(32'h03020100, 4'hF, 1'b0);
        push_exp(32'h07060504, 4'hF, 1'b0);
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            send(8'(i), 1'b0);
        end
        chk("stream_cycles", 64'(($time - t0) / 10), 64'd8);
        idle();
        @(negedge wr_clk_int);
        chk("stream_second_vld", 64'(m_axis_tvalid), 64'd1);
        tick();

        // Reset mid-packet
        send(8'hEE, 1'b0);
        send(8'hFF, 1'b0);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge wr_clk_int);
        chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst_tdata", 64'(m_axis_tdata), 64'd0);
        chk("midrst_lane", 64'(lane_cnt), 64'd0);
        tick();
        push_exp(32'h13121110, 4'hF, 1'b1);
        send(8'h10, 1'b0);
        send(8'h11, 1'b0);
        send(8'h12, 1'b0);
        send(8'h13, 1'b1);
        idle();
        repeat (3) tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
